// File: rtl/interval_irq_ctrl.sv
// Level interrupt controller fed by the interval timer tick.
// Counts accepted ticks and ticks lost while an interrupt is pending.
module interval_irq_ctrl #(
    parameter int CNT_W = 32,
    parameter int OVR_W = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic             ack_i,
    input  logic             clr_i,
    output logic             irq_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] tick_cnt_o,
    output logic [OVR_W-1:0] overrun_cnt_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        PENDING = 2'b10,
        BAD     = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             tick_d;
    logic             tick_rise;
    logic             accept;
    logic             lost;
    logic             irq_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic [OVR_W-1:0] ovr_cnt_q;
    logic             ovr_q;

    assign tick_rise = tick_i & ~tick_d;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        lost    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i)
                    state_d = ARMED;
            end
            ARMED: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (tick_rise) begin
                    state_d = PENDING;
                    accept  = 1'b1;
                end
            end
            PENDING: begin
                // ack retires the old interrupt before a same-cycle tick
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (tick_rise) begin
                    accept = ack_i;
                    lost   = ~ack_i;
                end else if (ack_i) begin
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            tick_d  <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= (state_d == PENDING);
            tick_d  <= tick_i;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            tick_cnt_q <= '0;
            ovr_cnt_q  <= '0;
            ovr_q      <= 1'b0;
        end else if (clr_i) begin
            tick_cnt_q <= '0;
            ovr_cnt_q  <= '0;
            ovr_q      <= 1'b0;
        end else begin
            if (accept)
                tick_cnt_q <= tick_cnt_q + CNT_W'(1);
            if (lost) begin
                ovr_q <= 1'b1;
                if (ovr_cnt_q != {OVR_W{1'b1}})
                    ovr_cnt_q <= ovr_cnt_q + OVR_W'(1);
            end
        end
    end

    assign irq_o         = irq_q;
    assign state_o       = state_q;
    assign tick_cnt_o    = tick_cnt_q;
    assign overrun_cnt_o = ovr_cnt_q;
    assign overrun_o     = ovr_q;

endmodule
